// File: rtl/pow8_rr_arbiter.sv
// Round-robin front end sharing one fixed-latency pow8 pipeline between NUM_REQ
// requesters; a tag shift register routes each result back to its owner.
module pow8_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int LATENCY = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [7*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_mask,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 pipe_i_valid,
  output logic [6:0]           pipe_i_data,
  input  logic                 pipe_o_valid,
  input  logic [63:0]          pipe_o_data,
  output logic [NUM_REQ-1:0]   rsp_valid,
  output logic [63:0]          rsp_data,
  output logic [3:0]           inflight,
  output logic                 tag_err
);

  localparam int             IDW          = $clog2(NUM_REQ);
  localparam logic [IDW:0]   NREQ_W       = (IDW+1)'(NUM_REQ);
  localparam logic [IDW-1:0] LAST_ID      = IDW'(NUM_REQ - 1);
  localparam logic [3:0]     INFLIGHT_MAX = 4'(LATENCY + 1);
  localparam logic [3:0]     SQUELCH_LEN  = 4'(LATENCY + 1);

  typedef struct packed {
    logic           v;
    logic [IDW-1:0] id;
  } tag_t;

  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] grant_oh;
  logic [IDW-1:0]     grant_id;
  logic [IDW-1:0]     scan_id;
  logic [IDW:0]       scan_sum;
  logic               found;
  logic               transfer;
  logic [6:0]         grant_data;

  logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
  logic               pipe_i_valid_q;
  logic [6:0]         pipe_i_data_q;
  logic [IDW-1:0]     issue_id_q;
  tag_t               tag_q [LATENCY+1];
  tag_t               tail;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [63:0]        rsp_data_q;
  logic [3:0]         inflight_q, inflight_d;
  logic               tag_err_q;
  logic [3:0]         squelch_q;
  logic               squelch;
  logic               ret_ok;
  logic               ret_err;

  assign elig = req_valid & req_mask;

  always_comb begin
    grant_oh = '0;
    grant_id = '0;
    found    = 1'b0;
    scan_sum = '0;
    scan_id  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan_sum = {1'b0, rr_ptr_q} + (IDW+1)'(i);
      if (scan_sum >= NREQ_W) scan_sum = scan_sum - NREQ_W;
      scan_id = scan_sum[IDW-1:0];
      if (!found && elig[scan_id]) begin
        found    = 1'b1;
        grant_id = scan_id;
      end
    end
    if (found && !rst) grant_oh[grant_id] = 1'b1;
  end

  assign transfer  = found && !rst;
  assign req_ready = grant_oh;

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_oh[i]) grant_data = req_data[7*i +: 7];
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (transfer) rr_ptr_d = (grant_id == LAST_ID) ? '0 : grant_id + IDW'(1);
  end

  // Results from ops issued before a reset may still drain out of the pipeline;
  // ignore the return port until the pipeline has been flushed.
  assign squelch = (squelch_q != 4'd0);
  assign tail    = tag_q[LATENCY];
  assign ret_ok  = !squelch && pipe_o_valid && tail.v;
  assign ret_err = !squelch && (pipe_o_valid != tail.v);

  always_comb begin
    rsp_valid_d = '0;
    if (ret_ok) rsp_valid_d[tail.id] = 1'b1;
  end

  always_comb begin
    inflight_d = inflight_q;
    if (pipe_i_valid_q && !ret_ok && inflight_q != INFLIGHT_MAX)
      inflight_d = inflight_q + 4'd1;
    else if (ret_ok && !pipe_i_valid_q && inflight_q != 4'd0)
      inflight_d = inflight_q - 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q       <= '0;
      pipe_i_valid_q <= 1'b0;
      pipe_i_data_q  <= '0;
      issue_id_q     <= '0;
      for (int k = 0; k <= LATENCY; k++) tag_q[k] <= '0;
      rsp_valid_q    <= '0;
      rsp_data_q     <= '0;
      inflight_q     <= '0;
      tag_err_q      <= 1'b0;
      squelch_q      <= SQUELCH_LEN;
    end else begin
      rr_ptr_q       <= rr_ptr_d;
      pipe_i_valid_q <= transfer;
      if (transfer) begin
        pipe_i_data_q <= grant_data;
        issue_id_q    <= grant_id;
      end
      // One slot past the pipeline depth so the tail lines up with pipe_o_valid.
      tag_q[0] <= {pipe_i_valid_q, issue_id_q};
      for (int k = 1; k <= LATENCY; k++) tag_q[k] <= tag_q[k-1];
      rsp_valid_q <= rsp_valid_d;
      if (ret_ok) rsp_data_q <= pipe_o_data;
      inflight_q <= inflight_d;
      if (ret_err) tag_err_q <= 1'b1;
      if (squelch) squelch_q <= squelch_q - 4'd1;
    end
  end

  assign pipe_i_valid = pipe_i_valid_q;
  assign pipe_i_data  = pipe_i_data_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign inflight     = inflight_q;
  assign tag_err      = tag_err_q;

endmodule

// File: tb/tb_pow8_rr_arbiter.sv
// Directed bench for pow8_rr_arbiter with a behavioural fixed-latency pow8 pipeline.
module tb_pow8_rr_arbiter;
  localparam int N   = 4;
  localparam int LAT = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req_valid = '0;
  logic [7*N-1:0] req_data = '0;
  logic [N-1:0]  req_mask = '1;
  logic [N-1:0]  req_ready;
  logic          pipe_i_valid;
  logic [6:0]    pipe_i_data;
  logic          pipe_o_valid;
  logic [63:0]   pipe_o_data;
  logic [N-1:0]  rsp_valid;
  logic [63:0]   rsp_data;
  logic [3:0]    inflight;
  logic          tag_err;

  int checks   = 0;
  int failures = 0;
  bit inject   = 1'b0;

  pow8_rr_arbiter #(.NUM_REQ(N), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_mask(req_mask), .req_ready(req_ready),
    .pipe_i_valid(pipe_i_valid), .pipe_i_data(pipe_i_data),
    .pipe_o_valid(pipe_o_valid), .pipe_o_data(pipe_o_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .inflight(inflight), .tag_err(tag_err)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] pow8(input logic [6:0] x);
    logic [63:0] r;
    r = {57'd0, x};
    r = r * r;
    r = r * r;
    r = r * r;
    return r;
  endfunction

  // Pipeline model: samples pipe_i_* at the edge after issue, returns LAT cycles later.
  bit       pv [0:LAT+1];
  bit [6:0] pd [0:LAT+1];
  always @(posedge clk) begin
    #1;
    for (int k = LAT + 1; k > 0; k--) begin
      pv[k] = pv[k-1];
      pd[k] = pd[k-1];
    end
    pv[0] = pipe_i_valid;
    pd[0] = pipe_i_data;
  end
  assign pipe_o_valid = pv[LAT+1] | inject;
  assign pipe_o_data  = pow8(pd[LAT+1]);

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 4'b1111; req_mask = 4'b1111; req_data = {7'd4, 7'd3, 7'd2, 7'd1};
    tick(); tick();
    #1;
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_ready got=%b exp=%b", req_ready, 4'b0000); end
    checks++; if (pipe_i_valid !== 1'b0) begin failures++; $display("FAIL reset_pipe_i_valid got=%b exp=0", pipe_i_valid); end
    checks++; if (pipe_i_data !== 7'd0) begin failures++; $display("FAIL reset_pipe_i_data got=%0d exp=0", pipe_i_data); end
    checks++; if (rsp_valid !== 4'b0000) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0000", rsp_valid); end
    checks++; if (rsp_data !== 64'd0) begin failures++; $display("FAIL reset_rsp_data got=%0d exp=0", rsp_data); end
    checks++; if (inflight !== 4'd0) begin failures++; $display("FAIL reset_inflight got=%0d exp=0", inflight); end
    checks++; if (tag_err !== 1'b0) begin failures++; $display("FAIL reset_tag_err got=%b exp=0", tag_err); end
    rst = 1'b0; req_valid = '0;
    repeat (2) tick();
  endtask

  task automatic test_single();
    int lat;
    req_data = {7'd0, 7'd0, 7'd0, 7'd2}; req_valid = 4'b0001; req_mask = 4'b1111;
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL single_ready got=%b exp=0001", req_ready); end
    tick();
    req_valid = '0;
    checks++; if (pipe_i_valid !== 1'b1 || pipe_i_data !== 7'd2) begin failures++; $display("FAIL single_issue got=%b/%0d exp=1/2", pipe_i_valid, pipe_i_data); end
    lat = 0;
    while (lat < 20) begin
      tick();
      lat++;
      if (lat == 1) begin
        checks++; if (inflight !== 4'd1) begin failures++; $display("FAIL single_inflight1 got=%0d exp=1", inflight); end
      end
      if (rsp_valid !== 4'b0000) break;
    end
    checks++; if (lat != LAT + 2) begin failures++; $display("FAIL single_latency got=%0d exp=%0d", lat, LAT + 2); end
    checks++; if (rsp_valid !== 4'b0001) begin failures++; $display("FAIL single_rsp_valid got=%b exp=0001", rsp_valid); end
    checks++; if (rsp_data !== 64'd256) begin failures++; $display("FAIL single_rsp_data got=%0d exp=256", rsp_data); end
    checks++; if (inflight !== 4'd0) begin failures++; $display("FAIL single_inflight0 got=%0d exp=0", inflight); end
    tick();
    checks++; if (rsp_valid !== 4'b0000 || rsp_data !== 64'd256) begin failures++; $display("FAIL single_rsp_hold got=%b/%0d exp=0000/256", rsp_valid, rsp_data); end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  exp_oh [4];
    logic [63:0] exp_d  [4];
    int rsp_n, first, last;
    logic [3:0] peak;
    exp_oh[0] = 4'b0001; exp_oh[1] = 4'b0010; exp_oh[2] = 4'b0100; exp_oh[3] = 4'b1000;
    exp_d[0] = 64'd1; exp_d[1] = 64'd256; exp_d[2] = 64'd6561; exp_d[3] = 64'd65536;
    rst = 1'b1; tick(); rst = 1'b0;
    rsp_n = 0; first = -1; last = -1; peak = '0;
    req_data = {7'd4, 7'd3, 7'd2, 7'd1}; req_valid = 4'b1111; req_mask = 4'b1111;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (c < 8) begin
        checks++; if (req_ready !== exp_oh[c%4]) begin failures++; $display("FAIL b2b_grant%0d got=%b exp=%b", c, req_ready, exp_oh[c%4]); end
      end
      tick();
      if (c == 7) req_valid = '0;
      if (inflight > peak) peak = inflight;
      if (rsp_valid !== 4'b0000) begin
        if (first < 0) first = c;
        last = c;
        checks++; if (rsp_n >= 8 || rsp_valid !== exp_oh[rsp_n%4] || rsp_data !== exp_d[rsp_n%4]) begin
          failures++; $display("FAIL b2b_rsp%0d got=%b/%0d exp=%b/%0d", rsp_n, rsp_valid, rsp_data, exp_oh[rsp_n%4], exp_d[rsp_n%4]);
        end
        rsp_n++;
      end
    end
    checks++; if (rsp_n != 8) begin failures++; $display("FAIL b2b_count got=%0d exp=8", rsp_n); end
    checks++; if (first != LAT + 2 || last != LAT + 9) begin failures++; $display("FAIL b2b_timing got=%0d..%0d exp=%0d..%0d", first, last, LAT + 2, LAT + 9); end
    checks++; if (peak !== 4'(LAT + 1)) begin failures++; $display("FAIL b2b_inflight_peak got=%0d exp=%0d", peak, LAT + 1); end
    checks++; if (inflight !== 4'd0) begin failures++; $display("FAIL b2b_inflight_end got=%0d exp=0", inflight); end
  endtask

  task automatic test_mask();
    int good, bad;
    req_data = {7'd5, 7'd0, 7'd2, 7'd0}; req_valid = 4'b1010; req_mask = 4'b0111;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL mask_grant%0d got=%b exp=0010", c, req_ready); end
      tick();
    end
    req_mask = 4'b1111;
    #1;
    checks++; if (req_ready !== 4'b1000) begin failures++; $display("FAIL mask_unmask got=%b exp=1000", req_ready); end
    req_mask = 4'b0111;
    #1;
    checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL mask_skip got=%b exp=0010", req_ready); end
    req_valid = '0;
    good = 0; bad = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (rsp_valid === 4'b0010 && rsp_data === 64'd256) good++;
      else if (rsp_valid !== 4'b0000) bad++;
    end
    checks++; if (good != 3 || bad != 0) begin failures++; $display("FAIL mask_rsp got=%0d/%0d exp=3/0", good, bad); end
    checks++; if (inflight !== 4'd0) begin failures++; $display("FAIL mask_inflight got=%0d exp=0", inflight); end
  endtask

  task automatic test_max_value();
    int lat;
    req_data = {7'd0, 7'd127, 7'd0, 7'd0}; req_valid = 4'b0100; req_mask = 4'b1111;
    #1;
    checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL max_ready got=%b exp=0100", req_ready); end
    tick();
    req_valid = '0;
    lat = 0;
    while (lat < 20) begin
      tick();
      lat++;
      if (rsp_valid !== 4'b0000) break;
    end
    checks++; if (lat != LAT + 2 || rsp_valid !== 4'b0100) begin failures++; $display("FAIL max_rsp_valid got=%b@%0d exp=0100@%0d", rsp_valid, lat, LAT + 2); end
    checks++; if (rsp_data !== 64'd67675234241018881) begin failures++; $display("FAIL max_rsp_data got=%0d exp=67675234241018881", rsp_data); end
    repeat (2) tick();
  endtask

  task automatic test_tag_err();
    inject = 1'b1;
    tick();
    inject = 1'b0;
    checks++; if (tag_err !== 1'b1 || rsp_valid !== 4'b0000) begin failures++; $display("FAIL tagerr_set got=%b/%b exp=1/0000", tag_err, rsp_valid); end
    tick(); tick();
    checks++; if (tag_err !== 1'b1 || rsp_valid !== 4'b0000 || inflight !== 4'd0) begin
      failures++; $display("FAIL tagerr_sticky got=%b/%b/%0d exp=1/0000/0", tag_err, rsp_valid, inflight);
    end
    rst = 1'b1;
    tick();
    checks++; if (tag_err !== 1'b0) begin failures++; $display("FAIL tagerr_clear got=%b exp=0", tag_err); end
    rst = 1'b0;
  endtask

  task automatic test_reset_midstream();
    int good, bad;
    req_data = {7'd4, 7'd3, 7'd2, 7'd1}; req_valid = 4'b1111; req_mask = 4'b1111;
    repeat (3) tick();
    req_valid = '0;
    tick();
    checks++; if (inflight !== 4'd3) begin failures++; $display("FAIL mid_inflight got=%0d exp=3", inflight); end
    rst = 1'b1; req_valid = 4'b1111;
    #1;
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL mid_ready_in_rst got=%b exp=0000", req_ready); end
    tick();
    checks++; if (pipe_i_valid !== 1'b0 || rsp_valid !== 4'b0000 || rsp_data !== 64'd0 || inflight !== 4'd0 || tag_err !== 1'b0) begin
      failures++; $display("FAIL mid_reset_vals got=%b/%b/%0d/%0d/%b exp=0/0000/0/0/0", pipe_i_valid, rsp_valid, rsp_data, inflight, tag_err);
    end
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL mid_ptr_restart got=%b exp=0001", req_ready); end
    tick();
    req_valid = '0;
    good = 0; bad = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (rsp_valid === 4'b0001 && rsp_data === 64'd1) good++;
      else if (rsp_valid !== 4'b0000) bad++;
    end
    checks++; if (good != 1 || bad != 0) begin failures++; $display("FAIL mid_rsp got=%0d/%0d exp=1/0", good, bad); end
    checks++; if (tag_err !== 1'b0 || inflight !== 4'd0) begin failures++; $display("FAIL mid_end got=%b/%0d exp=0/0", tag_err, inflight); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_mask();
    test_max_value();
    test_tag_err();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
